fpu_cmd_seq: RTL and testbench

FPU_CMD_SEQ -- requirements
Module: fpu_cmd_seq

---
 rtl/fpu_pkg.sv | 39 +++
 rtl/fpu_cmd_seq.sv | 167 ++++++++++++++++
 tb/tb_fpu_cmd_seq.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared constants for the FPU command sequencer: opcodes, canonical quiet NaN,
// response flag bit positions and the sequencer state encoding.
package fpu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_MUL  = 3'd1,
        OP_DIV  = 3'd2,
        OP_SQRT = 3'd3,
        OP_CMP  = 3'd4
    } fpu_op_e;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    localparam int unsigned FLG_OV  = 7;
    localparam int unsigned FLG_UN  = 6;
    localparam int unsigned FLG_INV = 5;
    localparam int unsigned FLG_INX = 4;
    localparam int unsigned FLG_DZ  = 3;
    localparam int unsigned FLG_LT  = 2;
    localparam int unsigned FLG_EQ  = 1;
    localparam int unsigned FLG_GT  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } seq_state_e;

    // Flag vector reported for any aborted command (bad opcode or timeout).
    function automatic logic [7:0] abort_flags();
        logic [7:0] f;
        f          = '0;
        f[FLG_INV] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/fpu_cmd_seq.sv
// Single-command sequencer in front of an FPU: reset pulse, run with timeout, held response.
// Optional sticky exception flags are built when FPU_SEQ_STICKY_FLAGS_EN is defined.
module fpu_cmd_seq
    import fpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_rm,
    output logic [31:0] fpu_in1,
    output logic [31:0] fpu_in2,
    output logic [2:0]  fpu_opcode,
    output logic [2:0]  fpu_round,
    output logic        fpu_act,
    output logic        fpu_rst,
    input  logic [31:0] fpu_out,
    input  logic        fpu_ov,
    input  logic        fpu_un,
    input  logic        fpu_inv,
    input  logic        fpu_inexact,
    input  logic        fpu_div_zero,
    input  logic        fpu_less,
    input  logic        fpu_eq,
    input  logic        fpu_great,
    input  logic        fpu_done,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [7:0]  rsp_flags,
    output logic        rsp_timeout,
    input  logic        flags_clr,
    output logic [4:0]  sticky_flags
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    seq_state_e       state_q, state_d;
    logic [2:0]       op_q, rm_q;
    logic [31:0]      a_q, b_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      res_q, res_d;
    logic [7:0]       flg_q, flg_d;
    logic             to_q, to_d;
    logic             hs_req, hs_rsp, bad_op, run_last;

    assign hs_req   = req_valid & req_ready;
    assign hs_rsp   = rsp_valid & rsp_ready;
    assign bad_op   = req_op > OP_CMP;
    assign run_last = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (hs_req) state_d = bad_op ? ST_RESP : ST_CLR;
            ST_CLR:  state_d = ST_RUN;
            ST_RUN:  if (fpu_done || run_last) state_d = ST_RESP;
            ST_RESP: if (hs_rsp) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        fpu_rst   = (state_q == ST_CLR);
        fpu_act   = (state_q == ST_RUN);
    end

    // Completion outranks timeout: the done branch is tested first.
    always_comb begin
        cnt_d = cnt_q;
        res_d = res_q;
        flg_d = flg_q;
        to_d  = to_q;
        case (state_q)
            ST_IDLE: begin
                if (hs_req && bad_op) begin
                    res_d = QNAN;
                    flg_d = abort_flags();
                    to_d  = 1'b0;
                end
            end
            ST_CLR: cnt_d = '0;
            ST_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (fpu_done) begin
                    res_d          = (op_q == OP_CMP) ? '0 : fpu_out;
                    flg_d          = '0;
                    flg_d[FLG_OV]  = fpu_ov;
                    flg_d[FLG_UN]  = fpu_un;
                    flg_d[FLG_INV] = fpu_inv;
                    flg_d[FLG_INX] = fpu_inexact;
                    flg_d[FLG_DZ]  = fpu_div_zero;
                    flg_d[FLG_LT]  = fpu_less;
                    flg_d[FLG_EQ]  = fpu_eq;
                    flg_d[FLG_GT]  = fpu_great;
                    to_d           = 1'b0;
                end else if (run_last) begin
                    res_d = QNAN;
                    flg_d = abort_flags();
                    to_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= '0;
            rm_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            res_q <= '0;
            flg_q <= '0;
            to_q  <= 1'b0;
        end else begin
            if (hs_req) begin
                op_q <= req_op;
                rm_q <= req_rm;
                a_q  <= req_a;
                b_q  <= req_b;
            end
            cnt_q <= cnt_d;
            res_q <= res_d;
            flg_q <= flg_d;
            to_q  <= to_d;
        end
    end

    assign fpu_in1     = a_q;
    assign fpu_in2     = b_q;
    assign fpu_opcode  = op_q;
    assign fpu_round   = rm_q;
    assign rsp_result  = res_q;
    assign rsp_flags   = flg_q;
    assign rsp_timeout = to_q;

`ifdef FPU_SEQ_STICKY_FLAGS_EN
    logic [4:0] sticky_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            sticky_q <= '0;
        else if (flags_clr) sticky_q <= '0;
        else if (hs_rsp)    sticky_q <= sticky_q | flg_q[FLG_OV:FLG_DZ];
    end

    assign sticky_flags = sticky_q;
`else
    logic unused_flags_clr;
    assign unused_flags_clr = flags_clr;
    assign sticky_flags     = '0;
`endif

endmodule

// File: tb/tb_fpu_cmd_seq.sv
// Directed bench for fpu_cmd_seq with a scripted FPU stub; follows FPU_SEQ_STICKY_FLAGS_EN.
module tb_fpu_cmd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [2:0]  req_op, req_rm;
    logic [31:0] req_a, req_b;
    logic [31:0] fpu_in1, fpu_in2;
    logic [2:0]  fpu_opcode, fpu_round;
    logic        fpu_act, fpu_rst;
    logic [31:0] fpu_out;
    logic        fpu_ov, fpu_un, fpu_inv, fpu_inexact, fpu_div_zero;
    logic        fpu_less, fpu_eq, fpu_great, fpu_done;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic [7:0]  rsp_flags;
    logic        rsp_timeout;
    logic        flags_clr;
    logic [4:0]  sticky_flags;

    int n_vec = 0;
    int n_err = 0;
    int cyc, act;

`ifdef FPU_SEQ_STICKY_FLAGS_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    fpu_cmd_seq #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_rm(req_rm),
        .fpu_in1(fpu_in1), .fpu_in2(fpu_in2), .fpu_opcode(fpu_opcode),
        .fpu_round(fpu_round), .fpu_act(fpu_act), .fpu_rst(fpu_rst),
        .fpu_out(fpu_out), .fpu_ov(fpu_ov), .fpu_un(fpu_un), .fpu_inv(fpu_inv),
        .fpu_inexact(fpu_inexact), .fpu_div_zero(fpu_div_zero),
        .fpu_less(fpu_less), .fpu_eq(fpu_eq), .fpu_great(fpu_great),
        .fpu_done(fpu_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
        .flags_clr(flags_clr), .sticky_flags(sticky_flags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] stk(input logic [4:0] v);
        return STICKY_EN ? {27'd0, v} : 32'd0;
    endfunction

    task automatic set_fpu(input logic done, input logic [31:0] out, input logic [7:0] fl);
        fpu_done = done;
        fpu_out  = out;
        {fpu_ov, fpu_un, fpu_inv, fpu_inexact, fpu_div_zero, fpu_less, fpu_eq, fpu_great} = fl;
    endtask

    // The stub raises done on RUN cycle 'lat' (never if lat < 0) and drives a
    // bogus done with junk data outside RUN, which the sequencer must ignore.
    task automatic run_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] rm, input int lat, input logic [31:0] out,
                           input logic [7:0] fl, output int n_cyc, output int n_act);
        int rcnt;
        rcnt = 0;
        @(negedge clk);
        check("req_ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rm = rm;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_rm = '0;
        n_cyc = 0;
        n_act = 0;
        while (n_cyc < 100) begin
            @(negedge clk);
            n_cyc++;
            if (rsp_valid) break;
            if (fpu_act) begin
                n_act++;
                if (rcnt == lat) set_fpu(1'b1, out, fl);
                else             set_fpu(1'b0, 32'hBAD0_BAD0, 8'hFF);
                rcnt++;
            end else begin
                set_fpu(1'b1, 32'hDEAD_BEEF, 8'hFF);
            end
        end
        if (!rsp_valid) check("rsp_wait_bound", 32'd0, 32'd1);
        set_fpu(1'b0, 32'd0, 8'd0);
    endtask

    task automatic accept(input int hold, input logic clr, input logic [31:0] res,
                          input logic [7:0] fl, input logic to);
        for (int i = 0; i < hold; i++) begin
            check("hold_valid",  32'(rsp_valid),   32'd1);
            check("hold_ready",  32'(req_ready),   32'd0);
            check("hold_result", rsp_result,       res);
            check("hold_flags",  32'(rsp_flags),   32'(fl));
            check("hold_tmo",    32'(rsp_timeout), 32'(to));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        flags_clr = clr;
        @(negedge clk);
        rsp_ready = 1'b0;
        flags_clr = 1'b0;
        check("after_rsp_req_ready", 32'(req_ready), 32'd1);
        check("after_rsp_valid",     32'(rsp_valid), 32'd0);
    endtask

    task automatic check_rsp(input string tag, input int exp_cyc, input int exp_act,
                             input logic [31:0] res, input logic [7:0] fl, input logic to);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_act_cyc"}, 32'(act), 32'(exp_act));
        check({tag, "_result"},  rsp_result, res);
        check({tag, "_flags"},   32'(rsp_flags), 32'(fl));
        check({tag, "_timeout"}, 32'(rsp_timeout), 32'(to));
    endtask

    task automatic pulse_clr();
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_rm = '0;
        rsp_ready = 1'b0; flags_clr = 1'b0;
        set_fpu(1'b0, 32'd0, 8'd0);
        repeat (3) @(negedge clk);
        check("rst_fpu_act",   32'(fpu_act),   32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready),    32'd1);
        check("rst_fpu_rst",   32'(fpu_rst),      32'd0);
        check("rst_in1",       fpu_in1,           32'd0);
        check("rst_in2",       fpu_in2,           32'd0);
        check("rst_opcode",    32'(fpu_opcode),   32'd0);
        check("rst_result",    rsp_result,        32'd0);
        check("rst_flags",     32'(rsp_flags),    32'd0);
        check("rst_sticky",    32'(sticky_flags), 32'd0);

        // 1.0 + 2.0 = 3.0, done on the first RUN cycle -> minimum latency 3
        run_req(3'd0, 32'h3F80_0000, 32'h4000_0000, 3'd0, 0, 32'h4040_0000, 8'h00, cyc, act);
        check_rsp("add", 3, 1, 32'h4040_0000, 8'h00, 1'b0);
        check("add_in1",    fpu_in1, 32'h3F80_0000);
        check("add_in2",    fpu_in2, 32'h4000_0000);
        check("add_opcode", 32'(fpu_opcode), 32'd0);
        accept(0, 1'b0, 32'd0, 8'd0, 1'b0);
        check("add_sticky", 32'(sticky_flags), 32'd0);

        // 1.0 / 0.0 = +inf with div_zero, done on RUN cycle 2
        run_req(3'd2, 32'h3F80_0000, 32'h0000_0000, 3'd1, 2, 32'h7F80_0000, 8'h08, cyc, act);
        check_rsp("div", 5, 3, 32'h7F80_0000, 8'h08, 1'b0);
        check("div_opcode", 32'(fpu_opcode), 32'd2);
        check("div_round",  32'(fpu_round),  32'd1);
        accept(0, 1'b0, 32'd0, 8'd0, 1'b0);
        check("div_sticky_set",  32'(sticky_flags), stk(5'b00001));
        @(negedge clk);
        check("div_sticky_hold", 32'(sticky_flags), stk(5'b00001));
        pulse_clr();
        check("div_sticky_clr",  32'(sticky_flags), 32'd0);

        // bad opcode: straight to response, FPU never activated; clear beats set
        run_req(3'd5, 32'h1, 32'h2, 3'd0, 0, 32'd0, 8'h00, cyc, act);
        check_rsp("badop", 1, 0, 32'h7FC0_0000, 8'h20, 1'b0);
        accept(0, 1'b1, 32'd0, 8'd0, 1'b0);
        check("badop_sticky_clrwin", 32'(sticky_flags), 32'd0);

        // sqrt with no done: 8 RUN cycles then timeout
        run_req(3'd3, 32'h4080_0000, 32'h0, 3'd0, -1, 32'd0, 8'h00, cyc, act);
        check_rsp("tmo", 10, 8, 32'h7FC0_0000, 8'h20, 1'b1);
        accept(0, 1'b0, 32'd0, 8'd0, 1'b0);
        check("tmo_sticky", 32'(sticky_flags), stk(5'b00100));
        pulse_clr();
        check("tmo_sticky_clr", 32'(sticky_flags), 32'd0);

        // compare 2.0 vs 1.0: result forced to 0, great set, response held 10 cycles
        run_req(3'd4, 32'h4000_0000, 32'h3F80_0000, 3'd0, 1, 32'h1234_5678, 8'h01, cyc, act);
        check_rsp("cmp", 4, 2, 32'd0, 8'h01, 1'b0);
        accept(10, 1'b0, 32'd0, 8'h01, 1'b0);
        check("cmp_sticky", 32'(sticky_flags), 32'd0);

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd0; req_a = 32'h3F80_0000; req_b = 32'h4000_0000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_clr_fpu_rst", 32'(fpu_rst), 32'd1);
        check("mid_clr_fpu_act", 32'(fpu_act), 32'd0);
        @(negedge clk);
        check("mid_run_fpu_act", 32'(fpu_act), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_fpu_act",   32'(fpu_act),   32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd1);
        check("arst_in1",       fpu_in1,        32'd0);
        check("arst_result",    rsp_result,     32'd0);
        check("arst_flags",     32'(rsp_flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);

        run_req(3'd0, 32'h3F80_0000, 32'h4000_0000, 3'd0, 0, 32'h4040_0000, 8'h00, cyc, act);
        check_rsp("add2", 3, 1, 32'h4040_0000, 8'h00, 1'b0);
        accept(0, 1'b0, 32'd0, 8'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
